// File: rtl/req_enc_pkg.sv
// Shared constants, FSM state encoding and index-to-onehot helper for the
// sequential 16-to-4 request encoder.
package req_enc_pkg;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // One-hot decode of a binary request index
    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_prio_encode16.sv
// Round-robin priority encoder: finds the first set bit of avail searching
// upward from ptr and wrapping 15 -> 0.
module rr_prio_encode16
    import req_enc_pkg::*;
(
    input  logic [N-1:0]     avail,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_found
);

    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] rel_idx;

    // Rotate so ptr lands at bit 0, encode LSB-first, then shift the result back by ptr
    always_comb begin
        rotated = N'({avail, avail} >> ptr);
        rel_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                rel_idx = IDX_W'(i);
            end
        end
        sel_found = |avail;
        sel_idx   = rel_idx + ptr;
    end

endmodule

// File: rtl/req_encoder_16to4.sv
// Sequential 16-to-4 request encoder: sticky pending requests are offered one
// index at a time over a valid/ready handshake with round-robin priority.
module req_encoder_16to4
    import req_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic             flush,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [IDX_W-1:0] idx_out,
    output logic [N-1:0]     onehot_out,
    output logic [N-1:0]     pending_out,
    output logic             coalesce_out
);

    state_t           state_q;
    logic [N-1:0]     pending_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic [N-1:0]     onehot_q;
    logic             valid_q;
    logic             coalesce_q;

    logic             accept;
    logic [N-1:0]     clear_mask;
    logic [N-1:0]     avail;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;

    // Accepted bit is removed before selection so the next offer never repeats it
    always_comb begin
        accept     = valid_q & ready_in;
        clear_mask = accept ? idx_to_onehot(idx_q) : '0;
        avail      = pending_q & ~clear_mask;
    end

    rr_prio_encode16 u_prio (
        .avail     (avail),
        .ptr       (ptr_q),
        .sel_idx   (sel_idx),
        .sel_found (sel_found)
    );

    // Pending register (new requests win over the clear) and coalesce pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            coalesce_q <= 1'b0;
        end else if (flush) begin
            pending_q  <= '0;
            coalesce_q <= 1'b0;
        end else begin
            pending_q  <= avail | req_in;
            coalesce_q <= |(req_in & avail);
        end
    end

    // Offer FSM: registered index, one-hot, valid and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
        end else if (flush) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        idx_q    <= sel_idx;
                        onehot_q <= idx_to_onehot(sel_idx);
                        valid_q  <= 1'b1;
                        state_q  <= OFFER;
                    end
                end
                OFFER: begin
                    if (ready_in) begin
                        ptr_q <= idx_q + IDX_W'(1);
                        if (sel_found) begin
                            idx_q    <= sel_idx;
                            onehot_q <= idx_to_onehot(sel_idx);
                        end else begin
                            onehot_q <= '0;
                            valid_q  <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid_out    = valid_q;
    assign idx_out      = idx_q;
    assign onehot_out   = onehot_q;
    assign pending_out  = pending_q;
    assign coalesce_out = coalesce_q;

endmodule
